// File: rtl/calc_pkg.sv
// Purpose: shared state encodings, opcodes and output-decode helper for the calculator sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

   // FSM state encodings (3-bit; codes 6 and 7 are illegal and recover to IDLE)
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_A = 3'd1;
   localparam logic [2:0] ST_LOAD_B = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_STORE  = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   // Opcodes, which double as result-mux select values
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   // Registered control outputs, bundled so they are decoded in one place
   typedef struct packed {
      logic [1:0] sel;
      logic       ld_a;
      logic       ld_b;
      logic       ld_r;
      logic       busy;
      logic       done;
   } ctrl_out_t;

   // Moore decode: outputs are a pure function of the state being entered.
   // The mux select parks on OP_ADD in IDLE so the result path is quiet.
   function automatic ctrl_out_t decode_outs(input logic [2:0] state, input logic [1:0] op_q);
      ctrl_out_t o;
      o      = '0;
      o.sel  = (state == ST_IDLE) ? OP_ADD : op_q;
      o.ld_a = (state == ST_LOAD_A);
      o.ld_b = (state == ST_LOAD_B);
      o.ld_r = (state == ST_STORE);
      o.done = (state == ST_DONE);
      o.busy = (state != ST_IDLE);
      return o;
   endfunction

endpackage

// File: rtl/calc_exec_timer.sv
// Purpose: loadable down-counter with zero flag, timing the EXEC phase of the sequencer.
// Latency: load/decrement take effect on the next rising edge; zero flag is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module calc_exec_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   // Load has priority over decrement; count never wraps below zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/calc_ctrl.sv
// Purpose: calculator control sequencer (IDLE->LOAD_A->LOAD_B->EXEC->STORE->DONE), Moore outputs.
// Latency: go sampled at edge N -> done high in cycle N+4+EXEC_CYCLES; period 5+EXEC_CYCLES.
// Backpressure: go/op ignored while busy; clr aborts to IDLE next edge. Option: CALC_CTRL_OP_COUNT_EN adds op_count.
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int EXEC_CYCLES = 2
`ifdef CALC_CTRL_OP_COUNT_EN
   ,
   parameter int CNT_W = 8
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic [1:0] op,
   input  logic       clr,
   output logic [1:0] sel,
   output logic       ld_a,
   output logic       ld_b,
   output logic       ld_r,
   output logic       busy,
   output logic       done
`ifdef CALC_CTRL_OP_COUNT_EN
   ,
   output logic [CNT_W-1:0] op_count
`endif
);

   localparam int TMR_W = $clog2(EXEC_CYCLES) + 1;

   logic [2:0]  r_state;
   logic [2:0]  w_nxt;
   logic [1:0]  r_op_q;
   logic [1:0]  w_op_nxt;
   logic        w_accept;
   logic        w_tmr_load;
   logic        w_tmr_zero;
   ctrl_out_t   r_out;

   // A request is taken only from IDLE, and an abort on the same edge drops it
   assign w_accept   = (r_state == ST_IDLE) && go && !clr;
   assign w_op_nxt   = w_accept ? op : r_op_q;
   // Timer is armed only on the edge that enters EXEC, so EXEC lasts EXEC_CYCLES cycles
   assign w_tmr_load = (w_nxt == ST_EXEC) && (r_state != ST_EXEC);

   calc_exec_timer #(
      .W (TMR_W)
   ) u_exec_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_tmr_load),
      .i_load_val (TMR_W'(EXEC_CYCLES - 1)),
      .i_dec      (r_state == ST_EXEC),
      .o_zero     (w_tmr_zero)
   );

   // Next-state logic; clr overrides everything and illegal codes fall back to IDLE
   always_comb begin
      w_nxt = ST_IDLE;
      case (r_state)
         ST_IDLE:   w_nxt = go ? ST_LOAD_A : ST_IDLE;
         ST_LOAD_A: w_nxt = ST_LOAD_B;
         ST_LOAD_B: w_nxt = ST_EXEC;
         ST_EXEC:   w_nxt = w_tmr_zero ? ST_STORE : ST_EXEC;
         ST_STORE:  w_nxt = ST_DONE;
         ST_DONE:   w_nxt = ST_IDLE;
         default:   w_nxt = ST_IDLE;
      endcase
      if (clr) begin
         w_nxt = ST_IDLE;
      end
   end

   // State, latched opcode and registered outputs decoded from the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op_q  <= OP_ADD;
         r_out   <= '0;
      end else begin
         r_state <= w_nxt;
         r_op_q  <= w_op_nxt;
         r_out   <= decode_outs(w_nxt, w_op_nxt);
      end
   end

   assign sel  = r_out.sel;
   assign ld_a = r_out.ld_a;
   assign ld_b = r_out.ld_b;
   assign ld_r = r_out.ld_r;
   assign busy = r_out.busy;
   assign done = r_out.done;

`ifdef CALC_CTRL_OP_COUNT_EN
   logic [CNT_W-1:0] r_op_count;

   // Count each cycle spent in DONE; wraps naturally, untouched by clr
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_count <= '0;
      end else if (r_state == ST_DONE) begin
         r_op_count <= r_op_count + CNT_W'(1);
      end
   end

   assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_calc_ctrl.sv
// Purpose: self-checking bench for calc_ctrl against a phase-count reference model.
// Latency: model predicts outputs each cycle; directed latency/period checks added on top.
// Backpressure: exercises go/op while busy, clr aborts and rst mid-operation.
module tb_calc_ctrl;

   localparam int E     = 2;
   localparam int LAST  = 4 + E;   // phase index of the done cycle (1 = load A)
   localparam int CW    = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       go  = 1'b0;
   logic [1:0] op  = 2'b00;
   logic       clr = 1'b0;
   logic [1:0] sel;
   logic       ld_a, ld_b, ld_r, busy, done;
`ifdef CALC_CTRL_OP_COUNT_EN
   logic [CW-1:0] op_count;
`endif

   always #5 clk = ~clk;

`ifdef CALC_CTRL_OP_COUNT_EN
   calc_ctrl #(.EXEC_CYCLES(E), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .go(go), .op(op), .clr(clr),
      .sel(sel), .ld_a(ld_a), .ld_b(ld_b), .ld_r(ld_r), .busy(busy), .done(done),
      .op_count(op_count));
`else
   calc_ctrl #(.EXEC_CYCLES(E)) dut (
      .clk(clk), .rst(rst), .go(go), .op(op), .clr(clr),
      .sel(sel), .ld_a(ld_a), .ld_b(ld_b), .ld_r(ld_r), .busy(busy), .done(done));
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model: ph = 0 idle, 1..LAST counts cycles into an operation
   int         m_ph  = 0;
   logic [1:0] m_op  = 2'b00;
   int         m_cnt = 0;

   int n_done = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
   endtask

   task automatic model_edge(input logic g, input logic [1:0] o, input logic c, input logic r);
      if (r) begin
         m_ph = 0; m_op = 2'b00; m_cnt = 0;
      end else begin
         if (m_ph == LAST) m_cnt = (m_cnt + 1) % (1 << CW);
         if (c) m_ph = 0;
         else if (m_ph == 0) begin
            if (g) begin m_ph = 1; m_op = o; end
         end
         else if (m_ph == LAST) m_ph = 0;
         else m_ph = m_ph + 1;
      end
   endtask

   task automatic compare();
      chk("sel",  int'(sel),  (m_ph != 0) ? int'(m_op) : 0);
      chk("ld_a", int'(ld_a), int'(m_ph == 1));
      chk("ld_b", int'(ld_b), int'(m_ph == 2));
      chk("ld_r", int'(ld_r), int'(m_ph == LAST - 1));
      chk("done", int'(done), int'(m_ph == LAST));
      chk("busy", int'(busy), int'(m_ph != 0));
`ifdef CALC_CTRL_OP_COUNT_EN
      chk("op_count", int'(op_count), m_cnt);
`endif
   endtask

   // One clock: drive inputs, let the edge happen, advance model, check at negedge
   task automatic cycle(input logic g, input logic [1:0] o, input logic c, input logic r);
      go = g; op = o; clr = c; rst = r;
      @(posedge clk);
      model_edge(g, o, c, r);
      cyc++;
      @(negedge clk);
      compare();
      if (done === 1'b1) n_done++;
   endtask

   int go_edge, done_edge, busy_cnt, last_done, d0;
   int exp_cnt [5] = '{1, 2, 3, 0, 1};

   initial begin
      @(negedge clk);

      // 1: reset for two cycles with go asserted
      cycle(1'b1, 2'b11, 1'b0, 1'b1);
      cycle(1'b1, 2'b11, 1'b0, 1'b1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sel",  int'(sel),  0);
      cycle(1'b0, 2'b00, 1'b0, 1'b0);

      // 2: single SUB; done high in the cycle ending at go edge + 4 + E
      cycle(1'b1, 2'b01, 1'b0, 1'b0);
      go_edge = cyc; done_edge = -1; busy_cnt = int'(busy);
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 2'b00, 1'b0, 1'b0);
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1 && done_edge < 0) done_edge = cyc;
      end
      chk("latency", (done_edge + 1) - go_edge, 4 + E);
      chk("busy_len", busy_cnt, 4 + E);

      // 3: go held high with XOR; done period is 5 + E
      last_done = -1; d0 = n_done;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b1, 2'b11, 1'b0, 1'b0);
         if (done === 1'b1) begin
            if (last_done >= 0) chk("period", cyc - last_done, 5 + E);
            last_done = cyc;
         end
      end
      chk("period_ops", n_done - d0, 4);
      for (int i = 0; i < 8; i++) cycle(1'b0, 2'b00, 1'b0, 1'b0);

      // 4: AND, with go/op toggled while busy
      d0 = n_done;
      cycle(1'b1, 2'b10, 1'b0, 1'b0);
      for (int i = 0; i < LAST + 3; i++) begin
         cycle(i[0], 2'(i), 1'b0, 1'b0);
         if (busy === 1'b1) chk("sel_held", int'(sel), 2);
         if (busy !== 1'b1) break;
      end
      chk("single_done", n_done - d0, 1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 1'b0, 1'b0);

      // 5: clr while in EXEC aborts; a following op completes
      d0 = n_done;
      cycle(1'b1, 2'b01, 1'b0, 1'b0);
      cycle(1'b0, 2'b00, 1'b0, 1'b0);
      cycle(1'b0, 2'b00, 1'b0, 1'b0);   // now in EXEC
      cycle(1'b0, 2'b00, 1'b1, 1'b0);
      chk("clr_busy", int'(busy), 0);
      chk("clr_sel",  int'(sel),  0);
      for (int i = 0; i < LAST; i++) cycle(1'b0, 2'b00, 1'b0, 1'b0);
      chk("clr_nodone", n_done - d0, 0);
      cycle(1'b1, 2'b11, 1'b0, 1'b0);
      for (int i = 0; i < LAST + 1; i++) cycle(1'b0, 2'b00, 1'b0, 1'b0);
      chk("after_clr", n_done - d0, 1);

`ifdef CALC_CTRL_OP_COUNT_EN
      // 6: op_count wraps at 2^CW; clr mid-op leaves it alone
      cycle(1'b0, 2'b00, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 2'(k), 1'b0, 1'b0);
         for (int i = 0; i < LAST; i++) cycle(1'b0, 2'b00, 1'b0, 1'b0);
         chk("cnt_seq", int'(op_count), exp_cnt[k]);
      end
      cycle(1'b1, 2'b00, 1'b0, 1'b0);
      cycle(1'b0, 2'b00, 1'b0, 1'b0);
      cycle(1'b0, 2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 1'b0, 1'b0);
      chk("cnt_clr", int'(op_count), 1);
`endif

      // Random phase: go/op/clr/rst mix checked against the model every cycle
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 39) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
